rpu_run_sequencer: RTL and testbench
====================================

Name: rpu_run_sequencer

Overview:
- Datapath-side responder to the RPU control FSM.
- Consumes the controller's busy level, learning-enable pulse and neuron-reset pulse.
- Produces neuron timestep ticks, a one-cycle done pulse ending each run, a synapse-address sweep with write strobes for learning, and a neuron-clear strobe.
- Sits between the controller and the neuron array / learning engine.

Parameters:
- NUM_STEPS, 16, default timesteps per run, used when run_len = 0.
- NUM_SYN, 8, synapses swept per learning pass, must be >= 1.
- CNT_W, 8, width of the timestep counter and run_len.
- ADDR_W, 3, width of syn_addr; 2^ADDR_W >= NUM_SYN.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- busy_in  in  1  controller busy level (high while the controller is running)
- learn_en  in  1  controller learning-enable pulse
- neuron_rst  in  1  controller neuron-reset pulse
- run_len  in  CNT_W  timesteps for next run; 0 selects NUM_STEPS
- tick  out  1  neuron update strobe, one per timestep
- timestep  out  CNT_W  index of current timestep
- done  out  1  one-cycle end-of-run pulse to controller
- syn_addr  out  ADDR_W  synapse index during learning
- learn_we  out  1  learning write strobe
- neuron_clr  out  1  one-cycle neuron state clear
- run_abort  out  1  one-cycle pulse when a run is cut short
- seq_state  out  3  encoded FSM state for debug: IDLE=0, RUN=1, WAIT_LEARN=2, LEARN=3, CLEAR=4

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - tick, done, learn_we, neuron_clr, run_abort = 0.
  - timestep = 0, syn_addr = 0.
  - Internal len register = 0, clr_pending = 0.
  - Reset mid-run or mid-sweep abandons the operation with no done and no clear pulse.
- Output timing:
  - tick, learn_we, neuron_clr and syn_addr are decoded from registered state and counters.
  - done and run_abort are registered pulses.
- IDLE:
  - If neuron_rst = 1 or clr_pending = 1, go to CLEAR. Clear has priority over starting a run.
  - Else if busy_in = 1, go to RUN, timestep <= 0, len <= (run_len == 0 ? NUM_STEPS : run_len).
  - busy_in is level-sensitive here.
- RUN:
  - tick = 1 every cycle; timestep shows the current index.
  - If busy_in = 0: go to IDLE, run_abort = 1 next cycle, no done.
  - Else if timestep == len-1: go to WAIT_LEARN, done = 1 for exactly the next cycle.
  - Else timestep <= timestep+1.
  - A run of L steps gives exactly L tick cycles. done is high in the cycle immediately after the last tick.
- WAIT_LEARN:
  - tick = 0; busy_in is ignored (the controller may still show busy during the done cycle).
  - learn_en = 1: go to LEARN with syn_addr <= 0. If neuron_rst is also high in the same cycle, set clr_pending.
  - neuron_rst = 1 alone: go to CLEAR with no learning.
- LEARN:
  - learn_we = 1 each cycle; syn_addr steps 0..NUM_SYN-1, one per cycle, for exactly NUM_SYN cycles.
  - neuron_rst seen in any LEARN cycle sets clr_pending; the sweep is not interrupted.
  - After the address NUM_SYN-1 cycle, go to IDLE. IDLE then routes to CLEAR if clr_pending is set.
  - syn_addr returns to 0 outside LEARN.
- CLEAR:
  - neuron_clr = 1 for one cycle; clr_pending <= 0; timestep <= 0; then IDLE.
  - neuron_rst arriving during CLEAR is absorbed and produces no second pulse.
- Other rules:
  - learn_en outside WAIT_LEARN is ignored.
  - timestep never wraps: the maximum is len-1 <= 2^CNT_W-1.
  - Counters compare with equality only; len = 1 yields one tick.

Test Plan:
- Nominal run: reset, run_len=0, busy_in high from cycle 2 until done is sampled -> 16 consecutive ticks with timestep 0..15; done high exactly one cycle, the cycle after timestep=15; no run_abort.
- Full controller handshake: done, then learn_en pulse, then neuron_rst pulse on the following cycle, NUM_SYN=8 -> learn_we for 8 cycles with syn_addr 0..7; clr_pending set; one neuron_clr pulse after the sweep; state returns to IDLE (0).
- Short run and back-to-back: run_len=1 -> exactly one tick with timestep=0, done the next cycle. Hold busy_in high again after CLEAR -> second run starts, timestep restarts at 0.
- Abort: run_len=5, drop busy_in after the 3rd tick -> run_abort one-cycle pulse, no done, state IDLE, timestep 0 on the next run.
- Reset-only path: neuron_rst in WAIT_LEARN with no learn_en -> no learn_we; neuron_clr one cycle. Simultaneous learn_en+neuron_rst -> full 8-address sweep, then exactly one neuron_clr.
- Async reset mid-LEARN at syn_addr=4: assert rst_n=0 between clock edges -> all outputs 0 immediately, state IDLE, no neuron_clr after release.

Source files
------------

// File: rtl/rpu_run_sequencer.sv
// rtl/rpu_run_sequencer.sv - datapath-side run/learn/clear sequencer answering the RPU control FSM
module rpu_run_sequencer #(
    parameter int NUM_STEPS = 16,
    parameter int NUM_SYN   = 8,
    parameter int CNT_W     = 8,
    parameter int ADDR_W    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              busy_in,
    input  logic              learn_en,
    input  logic              neuron_rst,
    input  logic [CNT_W-1:0]  run_len,
    output logic              tick,
    output logic [CNT_W-1:0]  timestep,
    output logic              done,
    output logic [ADDR_W-1:0] syn_addr,
    output logic              learn_we,
    output logic              neuron_clr,
    output logic              run_abort,
    output logic [2:0]        seq_state
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RUN        = 3'd1,
        S_WAIT_LEARN = 3'd2,
        S_LEARN      = 3'd3,
        S_CLEAR      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]  DEF_LEN  = CNT_W'(NUM_STEPS);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_SYN = ADDR_W'(NUM_SYN - 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  step_q, step_n;
    logic [CNT_W-1:0]  len_q, len_n;
    logic [ADDR_W-1:0] syn_q, syn_n;
    logic              clr_pending, clr_pending_n;
    logic              done_n, abort_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            step_q      <= '0;
            len_q       <= '0;
            syn_q       <= '0;
            clr_pending <= 1'b0;
            done        <= 1'b0;
            run_abort   <= 1'b0;
        end else begin
            state       <= state_n;
            step_q      <= step_n;
            len_q       <= len_n;
            syn_q       <= syn_n;
            clr_pending <= clr_pending_n;
            done        <= done_n;
            run_abort   <= abort_n;
        end
    end

    always_comb begin
        state_n       = state;
        step_n        = step_q;
        len_n         = len_q;
        syn_n         = syn_q;
        clr_pending_n = clr_pending;
        done_n        = 1'b0;
        abort_n       = 1'b0;
        unique case (state)
            S_IDLE: begin
                // A pending or fresh clear wins over starting a new run.
                if (neuron_rst || clr_pending) begin
                    state_n = S_CLEAR;
                end else if (busy_in) begin
                    state_n = S_RUN;
                    step_n  = '0;
                    len_n   = (run_len == '0) ? DEF_LEN : run_len;
                end
            end
            S_RUN: begin
                if (!busy_in) begin
                    state_n = S_IDLE;
                    abort_n = 1'b1;
                end else if (step_q == len_q - CNT_ONE) begin
                    state_n = S_WAIT_LEARN;
                    done_n  = 1'b1;
                end else begin
                    step_n = step_q + CNT_ONE;
                end
            end
            S_WAIT_LEARN: begin
                if (learn_en) begin
                    state_n = S_LEARN;
                    syn_n   = '0;
                    if (neuron_rst) clr_pending_n = 1'b1;
                end else if (neuron_rst) begin
                    state_n = S_CLEAR;
                end
            end
            S_LEARN: begin
                // The sweep always completes; a reset request is deferred to IDLE.
                if (neuron_rst) clr_pending_n = 1'b1;
                if (syn_q == LAST_SYN) begin
                    state_n = S_IDLE;
                    syn_n   = '0;
                end else begin
                    syn_n = syn_q + ADDR_ONE;
                end
            end
            S_CLEAR: begin
                state_n       = S_IDLE;
                clr_pending_n = 1'b0;
                step_n        = '0;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign tick       = (state == S_RUN);
    assign learn_we   = (state == S_LEARN);
    assign neuron_clr = (state == S_CLEAR);
    assign timestep   = step_q;
    assign syn_addr   = (state == S_LEARN) ? syn_q : '0;
    assign seq_state  = state;

endmodule

// File: tb/tb_rpu_run_sequencer.sv
// tb/tb_rpu_run_sequencer.sv - directed self-checking bench for rpu_run_sequencer
module tb_rpu_run_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy_in = 1'b0;
    logic       learn_en = 1'b0;
    logic       neuron_rst = 1'b0;
    logic [7:0] run_len = 8'd0;
    logic       tick;
    logic [7:0] timestep;
    logic       done;
    logic [2:0] syn_addr;
    logic       learn_we;
    logic       neuron_clr;
    logic       run_abort;
    logic [2:0] seq_state;

    int checks = 0;
    int passed = 0;

    rpu_run_sequencer #(.NUM_STEPS(16), .NUM_SYN(8), .CNT_W(8), .ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .busy_in(busy_in), .learn_en(learn_en),
        .neuron_rst(neuron_rst), .run_len(run_len), .tick(tick), .timestep(timestep),
        .done(done), .syn_addr(syn_addr), .learn_we(learn_we), .neuron_clr(neuron_clr),
        .run_abort(run_abort), .seq_state(seq_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs from IDLE with busy held until done; checks tick count, index sequence and done timing.
    task automatic run_to_done(input logic [7:0] len, input int exp_ticks, input string name);
        int n = 0;
        int bad_ts = 0;
        run_len = len;
        busy_in = 1'b1;
        step();
        while (tick && n < 300) begin
            if (timestep !== 8'(n) || done !== 1'b0 || run_abort !== 1'b0) bad_ts++;
            n++;
            step();
        end
        checks++; if (n !== exp_ticks) $display("FAIL %s_ticks got %0d want %0d", name, n, exp_ticks); else passed++;
        checks++; if (bad_ts !== 0) $display("FAIL %s_timestep_seq got %0d bad cycles want 0", name, bad_ts); else passed++;
        checks++; if (done !== 1'b1 || seq_state !== 3'd2) $display("FAIL %s_done got done=%0b state=%0d want done=1 state=2", name, done, seq_state); else passed++;
        checks++; if (run_abort !== 1'b0) $display("FAIL %s_no_abort got %0b want 0", name, run_abort); else passed++;
    endtask

    // Checks an 8-address sweep starting in the cycle after the caller's learn_en edge.
    task automatic check_sweep(input string name);
        int bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (learn_we !== 1'b1 || syn_addr !== 3'(i) || seq_state !== 3'd3 || neuron_clr !== 1'b0) bad++;
            neuron_rst = (i == 0);
            learn_en = 1'b0;
            step();
        end
        neuron_rst = 1'b0;
        checks++; if (bad !== 0) $display("FAIL %s_sweep got %0d bad cycles want 0", name, bad); else passed++;
        checks++; if (learn_we !== 1'b0 || syn_addr !== 3'd0 || seq_state !== 3'd0) $display("FAIL %s_after_sweep got we=%0b addr=%0d state=%0d want 0/0/0", name, learn_we, syn_addr, seq_state); else passed++;
    endtask

    task automatic test_reset();
        #12;
        checks++; if ({tick, done, learn_we, neuron_clr, run_abort} !== 5'b0) $display("FAIL reset_pulses got %b want 00000", {tick, done, learn_we, neuron_clr, run_abort}); else passed++;
        checks++; if (timestep !== 8'd0 || syn_addr !== 3'd0 || seq_state !== 3'd0) $display("FAIL reset_counters got ts=%0d addr=%0d state=%0d want 0/0/0", timestep, syn_addr, seq_state); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (seq_state !== 3'd0 || tick !== 1'b0) $display("FAIL reset_idle_hold got state=%0d tick=%0b want 0/0", seq_state, tick); else passed++;
    endtask

    task automatic test_nominal_and_handshake();
        run_to_done(8'd0, 16, "nominal");
        busy_in = 1'b0;
        learn_en = 1'b1;
        step();
        check_sweep("handshake");
        checks++; if (neuron_clr !== 1'b0) $display("FAIL handshake_clr_wait got %0b want 0", neuron_clr); else passed++;
        step();
        checks++; if (neuron_clr !== 1'b1 || seq_state !== 3'd4 || timestep !== 8'd15) $display("FAIL handshake_clr got clr=%0b state=%0d ts=%0d want 1/4/15", neuron_clr, seq_state, timestep); else passed++;
        step();
        checks++; if (neuron_clr !== 1'b0 || seq_state !== 3'd0 || timestep !== 8'd0) $display("FAIL handshake_idle got clr=%0b state=%0d ts=%0d want 0/0/0", neuron_clr, seq_state, timestep); else passed++;
        step();
        checks++; if (neuron_clr !== 1'b0 || seq_state !== 3'd0) $display("FAIL handshake_single_clr got clr=%0b state=%0d want 0/0", neuron_clr, seq_state); else passed++;
    endtask

    task automatic test_back_to_back();
        run_to_done(8'd1, 1, "short");
        neuron_rst = 1'b1;
        step();
        neuron_rst = 1'b0;
        checks++; if (neuron_clr !== 1'b1 || learn_we !== 1'b0 || seq_state !== 3'd4) $display("FAIL rst_only_clr got clr=%0b we=%0b state=%0d want 1/0/4", neuron_clr, learn_we, seq_state); else passed++;
        step();
        checks++; if (seq_state !== 3'd0 || neuron_clr !== 1'b0 || learn_we !== 1'b0) $display("FAIL rst_only_idle got state=%0d clr=%0b we=%0b want 0/0/0", seq_state, neuron_clr, learn_we); else passed++;
        run_to_done(8'd1, 1, "back_to_back");
        busy_in = 1'b0;
        neuron_rst = 1'b1;
        step();
        neuron_rst = 1'b0;
        step();
    endtask

    task automatic test_abort();
        run_len = 8'd5;
        busy_in = 1'b1;
        for (int i = 0; i < 3; i++) step();
        checks++; if (tick !== 1'b1 || timestep !== 8'd2) $display("FAIL abort_third_tick got tick=%0b ts=%0d want 1/2", tick, timestep); else passed++;
        busy_in = 1'b0;
        step();
        checks++; if (run_abort !== 1'b1 || done !== 1'b0 || tick !== 1'b0 || seq_state !== 3'd0) $display("FAIL abort_pulse got abort=%0b done=%0b tick=%0b state=%0d want 1/0/0/0", run_abort, done, tick, seq_state); else passed++;
        step();
        checks++; if (run_abort !== 1'b0 || done !== 1'b0) $display("FAIL abort_one_cycle got abort=%0b done=%0b want 0/0", run_abort, done); else passed++;
        run_to_done(8'd5, 5, "after_abort");
        busy_in = 1'b0;
    endtask

    task automatic test_simultaneous_learn_rst();
        int clr_cnt = 0;
        learn_en = 1'b1;
        neuron_rst = 1'b1;
        step();
        check_sweep("simul");
        for (int i = 0; i < 4; i++) begin
            if (neuron_clr === 1'b1) clr_cnt++;
            step();
        end
        checks++; if (clr_cnt !== 1) $display("FAIL simul_clr_count got %0d want 1", clr_cnt); else passed++;
    endtask

    task automatic test_async_reset_mid_learn();
        int clr_cnt = 0;
        int guard = 0;
        run_to_done(8'd1, 1, "pre_reset");
        busy_in = 1'b0;
        learn_en = 1'b1;
        neuron_rst = 1'b1;
        step();
        learn_en = 1'b0;
        neuron_rst = 1'b0;
        while (syn_addr !== 3'd4 && guard < 20) begin
            guard++;
            step();
        end
        checks++; if (syn_addr !== 3'd4 || learn_we !== 1'b1) $display("FAIL async_reach_addr4 got addr=%0d we=%0b want 4/1", syn_addr, learn_we); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({tick, done, learn_we, neuron_clr, run_abort} !== 5'b0 || syn_addr !== 3'd0 || seq_state !== 3'd0 || timestep !== 8'd0) $display("FAIL async_reset_outputs got pulses=%b addr=%0d state=%0d ts=%0d want 0", {tick, done, learn_we, neuron_clr, run_abort}, syn_addr, seq_state, timestep); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (neuron_clr === 1'b1 || seq_state !== 3'd0) clr_cnt++;
        end
        checks++; if (clr_cnt !== 0) $display("FAIL async_no_clr_after got %0d bad cycles want 0", clr_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_nominal_and_handshake();
        test_back_to_back();
        test_abort();
        test_simultaneous_learn_rst();
        test_async_reset_mid_learn();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got still running want finished");
        $fatal(1);
    end

endmodule
